dmem_access_ctrl: RTL

- Shares the single 4-lane, byte-wide data memory between two requesters: the core load/store port and a DMA port.
- Sequences each access: arbitration, byte-lane write-enable and lane-data generation from address/size, synchronous-read capture, and load extraction with sign/zero extension.
- Sits between the core LSU / DMA engine and the four byte-bank data RAM (1-cycle synchronous read).

---
 rtl/dmem_access_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the core LSU and DMA ports onto a single 4-lane byte-banked data RAM.
// Optional DMEM_ERR_STICKY_EN adds a sticky core-error flag with the captured address.
module dmem_access_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [1:0]        core_size,
    input  logic              core_unsigned,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    output logic              core_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
`ifdef DMEM_ERR_STICKY_EN
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr,
`endif
    output logic              mem_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_wen1,
    output logic              mem_wen2,
    output logic              mem_wen3,
    output logic              mem_wen4,
    output logic [7:0]        mem_wdata1,
    output logic [7:0]        mem_wdata2,
    output logic [7:0]        mem_wdata3,
    output logic [7:0]        mem_wdata4,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              sel_dma_q, sel_dma_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              arb_edge, arb_go, dma_win;
    logic              legal;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_data;
    logic [31:0]       rd_shift;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    // Arbitration happens on every edge that leaves IDLE or RSP.
    assign arb_edge = (state_q != ACC);
    assign arb_go   = arb_edge && (core_req || dma_req);
    assign dma_win  = dma_req && (!core_req || (starve_q == CNT_W'(STARVE_MAX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RSP: state_d = (core_req || dma_req) ? ACC : IDLE;
            ACC:       state_d = RSP;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d  = starve_q;
        sel_dma_d = sel_dma_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (arb_edge) begin
            if (!dma_req || dma_win)                 starve_d = '0;
            else if (starve_q != CNT_W'(STARVE_MAX)) starve_d = starve_q + CNT_W'(1);
        end
        if (arb_go) begin
            sel_dma_d = dma_win;
            if (dma_win) begin
                // DMA is always a full word; low address bits drop out in the lane decode.
                we_d    = dma_we;
                size_d  = 2'b10;
                uns_d   = 1'b0;
                addr_d  = dma_addr;
                wdata_d = dma_wdata;
            end else begin
                we_d    = core_we;
                size_d  = core_size;
                uns_d   = core_unsigned;
                addr_d  = core_addr;
                wdata_d = core_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            sel_dma_q <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            starve_q  <= starve_d;
            sel_dma_q <= sel_dma_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign legal = sel_dma_q
                || (size_q == 2'b00)
                || (size_q == 2'b01 && !addr_q[0])
                || (size_q == 2'b10 && addr_q[1:0] == 2'b00);

    always_comb begin
        case (size_q)
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        case (size_q)
            2'b00:   lane_data = {4{wdata_q[7:0]}};
            2'b01:   lane_data = {2{wdata_q[15:0]}};
            default: lane_data = wdata_q;
        endcase
    end

    assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{!uns_q && rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = {{16{!uns_q && half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        core_gnt    = 1'b0;
        core_rvalid = 1'b0;
        core_rdata  = '0;
        core_err    = 1'b0;
        dma_gnt     = 1'b0;
        dma_rvalid  = 1'b0;
        dma_rdata   = '0;
        mem_en      = 1'b0;
        {mem_wen4, mem_wen3, mem_wen2, mem_wen1} = 4'b0000;
        mem_addr    = addr_q[ADDR_W-1:2];
        {mem_wdata4, mem_wdata3, mem_wdata2, mem_wdata1} = lane_data;
        case (state_q)
            ACC: begin
                core_gnt = !sel_dma_q;
                dma_gnt  = sel_dma_q;
                mem_en   = legal;
                if (legal && we_q) {mem_wen4, mem_wen3, mem_wen2, mem_wen1} = lane_mask;
            end
            RSP: begin
                if (sel_dma_q) begin
                    dma_rvalid = 1'b1;
                    dma_rdata  = we_q ? 32'h0 : mem_rdata;
                end else begin
                    core_rvalid = 1'b1;
                    core_err    = !legal;
                    core_rdata  = (legal && !we_q) ? load_ext : 32'h0;
                end
            end
            default: ;
        endcase
    end

`ifdef DMEM_ERR_STICKY_EN
    logic              err_sticky_q, err_sticky_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // A fresh error outranks a simultaneous clear so it is never lost.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_addr_d   = '0;
        end
        if (core_err && (!err_sticky_q || err_clr)) begin
            err_sticky_d = 1'b1;
            err_addr_d   = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;
`endif

endmodule
